// File: rtl/uart_pkg.sv
// Shared UART receive definitions: baud encodings, default 16x tick divisors, receiver FSM states.
package uart_pkg;

  localparam logic [1:0] BAUD24  = 2'b00;
  localparam logic [1:0] BAUD48  = 2'b01;
  localparam logic [1:0] BAUD96  = 2'b10;
  localparam logic [1:0] BAUD192 = 2'b11;

  // Clocks per 16x tick at a 50 MHz core clock
  localparam int DIV_2400_DEF  = 1302;
  localparam int DIV_4800_DEF  = 651;
  localparam int DIV_9600_DEF  = 326;
  localparam int DIV_19200_DEF = 163;

  localparam int TICK_W = 14;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_e;

endpackage

// File: rtl/uart_rx_tick_gen.sv
// 16x oversampling tick: one-clock pulse every DIV clocks, divisor captured and phase reset on clear.
// Latency: first tick DIV clocks after clear; no backpressure, free-running.
module uart_rx_tick_gen
  import uart_pkg::*;
#(
  parameter int DIV_2400  = DIV_2400_DEF,
  parameter int DIV_4800  = DIV_4800_DEF,
  parameter int DIV_9600  = DIV_9600_DEF,
  parameter int DIV_19200 = DIV_19200_DEF
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] baud_rate,
  input  logic       clear,
  output logic       tick
);

  logic [TICK_W-1:0] div_sel;
  logic [TICK_W-1:0] div_q;
  logic [TICK_W-1:0] cnt_q;

  always_comb begin
    div_sel = TICK_W'(DIV_19200);
    case (baud_rate)
      BAUD24:  div_sel = TICK_W'(DIV_2400);
      BAUD48:  div_sel = TICK_W'(DIV_4800);
      BAUD96:  div_sel = TICK_W'(DIV_9600);
      default: div_sel = TICK_W'(DIV_19200);
    endcase
  end

  assign tick = (cnt_q == (div_q - TICK_W'(1)));

  // Divisor only follows baud_rate at clear, so a mid-frame baud change cannot skew the frame
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      div_q <= TICK_W'(DIV_2400);
    end else if (clear) begin
      cnt_q <= '0;
      div_q <= div_sel;
    end else if (tick) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver (8N1/8E1/8O1) with 16x oversampling and mid-bit sampling; byte plus error flags on a data_valid pulse.
// Latency: data_valid 1 clock after stop-bit mid-sample (+2 sync clocks); no backpressure, host must take each pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0,
  parameter int DIV_2400   = DIV_2400_DEF,
  parameter int DIV_4800   = DIV_4800_DEF,
  parameter int DIV_9600   = DIV_9600_DEF,
  parameter int DIV_19200  = DIV_19200_DEF
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [1:0]           baud_rate,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_W = $clog2(DATA_BITS + 1);

  rx_state_e            state_q;
  rx_state_e            state_d;
  logic                 rx_meta;
  logic                 rx_s;
  logic                 tick;
  logic                 tick_clr;
  logic                 mid_tick;
  logic                 end_tick;
  logic [3:0]           tick_cnt;
  logic [IDX_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_bad_q;

  uart_rx_tick_gen #(
    .DIV_2400  (DIV_2400),
    .DIV_4800  (DIV_4800),
    .DIV_9600  (DIV_9600),
    .DIV_19200 (DIV_19200)
  ) u_tick_gen (
    .clock     (clock),
    .reset_n   (reset_n),
    .baud_rate (baud_rate),
    .clear     (tick_clr),
    .tick      (tick)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_in;
      rx_s    <= rx_meta;
    end
  end

  assign mid_tick = tick && (tick_cnt == 4'd7);
  assign end_tick = tick && (tick_cnt == 4'd15);
  assign busy     = (state_q != IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    tick_clr = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d  = START;
          tick_clr = 1'b1;
        end
      end
      START:  if (mid_tick) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (end_tick && (bit_idx == IDX_W'(DATA_BITS - 1)))
          state_d = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (end_tick) state_d = STOP;
      STOP:   if (end_tick) state_d = rx_s ? IDLE : BREAK;
      BREAK:  if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift_q    <= '0;
      par_bad_q  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      if (tick) tick_cnt <= tick_cnt + 4'd1;
      case (state_q)
        IDLE: begin
          tick_cnt  <= '0;
          bit_idx   <= '0;
          par_bad_q <= 1'b0;
        end
        // Re-phase the bit counter at the start-bit centre so later samples land mid-bit
        START: if (mid_tick) tick_cnt <= '0;
        DATA: begin
          if (end_tick) begin
            shift_q <= {rx_s, shift_q[DATA_BITS-1:1]};
            bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        PARITY: begin
          if (end_tick) par_bad_q <= (^shift_q) ^ rx_s ^ 1'(PARITY_ODD);
        end
        STOP: begin
          if (end_tick) begin
            data_out   <= shift_q;
            parity_err <= (PARITY_EN != 0) ? par_bad_q : 1'b0;
            frame_err  <= ~rx_s;
            data_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core with scaled-down divisors; frames are generated and predicted from UART framing rules.
module tb_uart_rx_core;

  localparam int D24  = 32;
  localparam int D48  = 16;
  localparam int D96  = 8;
  localparam int D192 = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] baud_rate;
  logic       rx_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       parity_err;
  logic       frame_err;
  logic       busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         dv_count = 0;
  logic [7:0] cap_data;
  logic       cap_perr;
  logic       cap_ferr;

  always #10 clock = ~clock;

  uart_rx_core #(
    .DATA_BITS  (8),
    .PARITY_EN  (1),
    .PARITY_ODD (0),
    .DIV_2400   (D24),
    .DIV_4800   (D48),
    .DIV_9600   (D96),
    .DIV_19200  (D192)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .baud_rate  (baud_rate),
    .rx_in      (rx_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .busy       (busy)
  );

  always @(negedge clock) begin
    if (data_valid === 1'b1) begin
      dv_count = dv_count + 1;
      cap_data = data_out;
      cap_perr = parity_err;
      cap_ferr = frame_err;
    end
  end

  function automatic int bit_clocks(input logic [1:0] b);
    case (b)
      2'b00:   return 16 * D24;
      2'b01:   return 16 * D48;
      2'b10:   return 16 * D96;
      default: return 16 * D192;
    endcase
  endfunction

  // Even parity: the data bits plus the parity bit must hold an even number of ones
  function automatic logic model_perr(input logic [7:0] d, input logic par);
    return ((($countones(d) + int'(par)) % 2) != 0);
  endfunction

  function automatic logic even_bit(input logic [7:0] d);
    return logic'($countones(d) % 2);
  endfunction

  // Drives start, 8 data bits LSB first, parity and stop (held stop_bits bit-times) at the line rate of line_baud
  task automatic drive_frame(input logic [1:0] line_baud, input logic [7:0] d, input logic par,
                             input logic stop, input int stop_bits, input int sw_bit,
                             input logic [1:0] sw_baud, input bit release_line);
    int bc;
    logic [9:0] bits;
    bc   = bit_clocks(line_baud);
    bits = {par, d, 1'b0};
    @(negedge clock);
    for (int i = 0; i < 10; i++) begin
      if (i == sw_bit) baud_rate = sw_baud;
      rx_in = bits[i];
      repeat (bc) @(negedge clock);
    end
    rx_in = stop;
    repeat (bc * stop_bits) @(negedge clock);
    if (release_line) rx_in = 1'b1;
  endtask

  task automatic idle_gap(input logic [1:0] b);
    repeat (bit_clocks(b)) @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    rx_in     = 1'b1;
    baud_rate = 2'b10;
    repeat (4) @(negedge clock);
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_parity_err: got %b expected 0", parity_err); end
    n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
  endtask

  task automatic test_even_parity;
    int dv0;
    logic p;
    baud_rate = 2'b10;
    p   = even_bit(8'hA5);
    dv0 = dv_count;
    drive_frame(2'b10, 8'hA5, p, 1'b1, 1, -1, 2'b10, 1'b1);
    idle_gap(2'b10);
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL even_dv_count: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (cap_data !== 8'hA5) begin n_fail++; $display("FAIL even_data: got %h expected a5", cap_data); end
    n_checks++; if (cap_perr !== model_perr(8'hA5, p)) begin n_fail++; $display("FAIL even_perr: got %b expected %b", cap_perr, model_perr(8'hA5, p)); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL even_ferr: got %b expected 0", cap_ferr); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL even_busy_idle: got %b expected 0", busy); end
  endtask

  task automatic test_parity_error;
    int dv0;
    baud_rate = 2'b11;
    dv0 = dv_count;
    drive_frame(2'b11, 8'h3C, 1'b1, 1'b1, 1, -1, 2'b11, 1'b1);
    idle_gap(2'b11);
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL perr_dv_count: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (cap_data !== 8'h3C) begin n_fail++; $display("FAIL perr_data: got %h expected 3c", cap_data); end
    n_checks++; if (cap_perr !== model_perr(8'h3C, 1'b1)) begin n_fail++; $display("FAIL perr_flag: got %b expected %b", cap_perr, model_perr(8'h3C, 1'b1)); end
    n_checks++; if (cap_ferr !== 1'b0) begin n_fail++; $display("FAIL perr_ferr: got %b expected 0", cap_ferr); end
  endtask

  task automatic test_break;
    int dv0;
    int waited;
    baud_rate = 2'b00;
    dv0 = dv_count;
    drive_frame(2'b00, 8'h00, even_bit(8'h00), 1'b0, 3, -1, 2'b00, 1'b0);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL break_busy_low: got %b expected 1", busy); end
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL break_dv_count: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (cap_ferr !== 1'b1) begin n_fail++; $display("FAIL break_ferr: got %b expected 1", cap_ferr); end
    n_checks++; if (cap_data !== 8'h00) begin n_fail++; $display("FAIL break_data: got %h expected 00", cap_data); end
    rx_in  = 1'b1;
    waited = 0;
    while (busy !== 1'b0 && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL break_busy_release: got %b expected 0 within 50 clocks", busy); end
    idle_gap(2'b00);
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL break_no_second_dv: got %0d expected 1", dv_count - dv0); end
  endtask

  task automatic test_glitch;
    int dv0;
    baud_rate = 2'b10;
    dv0 = dv_count;
    @(negedge clock);
    rx_in = 1'b0;
    repeat (4 * D96) @(negedge clock);
    rx_in = 1'b1;
    idle_gap(2'b10);
    n_checks++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL glitch_dv: got %0d expected 0", dv_count - dv0); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
  endtask

  task automatic test_baud_switch;
    int dv0;
    baud_rate = 2'b01;
    dv0 = dv_count;
    drive_frame(2'b01, 8'h5A, even_bit(8'h5A), 1'b1, 1, 4, 2'b11, 1'b1);
    idle_gap(2'b01);
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL switch_dv1: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (cap_data !== 8'h5A) begin n_fail++; $display("FAIL switch_data1: got %h expected 5a", cap_data); end
    n_checks++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin n_fail++; $display("FAIL switch_err1: got perr=%b ferr=%b expected 0 0", cap_perr, cap_ferr); end
    drive_frame(2'b11, 8'hC3, even_bit(8'hC3), 1'b1, 1, -1, 2'b11, 1'b1);
    idle_gap(2'b11);
    n_checks++; if (dv_count - dv0 !== 2) begin n_fail++; $display("FAIL switch_dv2: got %0d expected 2", dv_count - dv0); end
    n_checks++; if (cap_data !== 8'hC3) begin n_fail++; $display("FAIL switch_data2: got %h expected c3", cap_data); end
    n_checks++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin n_fail++; $display("FAIL switch_err2: got perr=%b ferr=%b expected 0 0", cap_perr, cap_ferr); end
  endtask

  task automatic test_reset_midframe;
    int dv0;
    int bc;
    logic [7:0] d;
    baud_rate = 2'b10;
    bc  = bit_clocks(2'b10);
    dv0 = dv_count;
    d   = 8'hFF;
    @(negedge clock);
    rx_in = 1'b0;
    repeat (bc) @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rx_in = d[i];
      repeat (bc) @(negedge clock);
    end
    rx_in = d[3];
    repeat (bc / 2) @(negedge clock);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_mid_busy_before: got %b expected 1", busy); end
    reset_n = 1'b0;
    #1;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_data_out: got %h expected 00", data_out); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_checks++; if (data_valid !== 1'b0 || parity_err !== 1'b0 || frame_err !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got dv=%b perr=%b ferr=%b expected 0 0 0", data_valid, parity_err, frame_err);
    end
    rx_in = 1'b1;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    repeat (2 * bc) @(negedge clock);
    n_checks++; if (dv_count - dv0 !== 0) begin n_fail++; $display("FAIL rst_mid_aborted_dv: got %0d expected 0", dv_count - dv0); end
    drive_frame(2'b10, 8'h81, even_bit(8'h81), 1'b1, 1, -1, 2'b10, 1'b1);
    idle_gap(2'b10);
    n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL rst_mid_next_dv: got %0d expected 1", dv_count - dv0); end
    n_checks++; if (cap_data !== 8'h81) begin n_fail++; $display("FAIL rst_mid_next_data: got %h expected 81", cap_data); end
    n_checks++; if (cap_perr !== 1'b0 || cap_ferr !== 1'b0) begin n_fail++; $display("FAIL rst_mid_next_err: got perr=%b ferr=%b expected 0 0", cap_perr, cap_ferr); end
  endtask

  task automatic test_random;
    int dv0;
    logic [1:0] b;
    logic [7:0] d;
    logic p;
    logic s;
    for (int n = 0; n < 20; n++) begin
      b = 2'($urandom_range(1, 3));
      d = 8'($urandom_range(0, 255));
      p = ($urandom_range(0, 3) == 0) ? ~even_bit(d) : even_bit(d);
      s = ($urandom_range(0, 4) != 0);
      baud_rate = b;
      dv0 = dv_count;
      drive_frame(b, d, p, s, 1, -1, b, 1'b1);
      idle_gap(b);
      n_checks++; if (dv_count - dv0 !== 1) begin n_fail++; $display("FAIL rand%0d_dv: got %0d expected 1", n, dv_count - dv0); end
      n_checks++; if (cap_data !== d) begin n_fail++; $display("FAIL rand%0d_data: got %h expected %h", n, cap_data, d); end
      n_checks++; if (cap_perr !== model_perr(d, p)) begin n_fail++; $display("FAIL rand%0d_perr: got %b expected %b", n, cap_perr, model_perr(d, p)); end
      n_checks++; if (cap_ferr !== ~s) begin n_fail++; $display("FAIL rand%0d_ferr: got %b expected %b", n, cap_ferr, ~s); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand%0d_busy: got %b expected 0", n, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_parity_error();
    test_break();
    test_glitch();
    test_baud_switch();
    test_reset_midframe();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
